// File: rtl/uart_wb_arbiter_if.sv
// Wishbone-style register port bundle used on both sides of the UART arbiter.
//
// Signals:
//   stb    request strobe, held by the requester until ack/err
//   we     UART polarity: 0 = write, 1 = read
//   addr   2-bit UART register address
//   wdata  8-bit write data
//   rdata  8-bit read data
//   ack    transfer done
//   err    transfer timed out (master-facing ports only)
//
// Modports:
//   master     a requester (CPU or loader) driving a request
//   slave      the arbiter's view of a requester port
//   initiator  the arbiter's view of the UART, which has no err line
interface uart_wb_arbiter_if;
  logic       stb;
  logic       we;
  logic [1:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       ack;
  logic       err;

  modport master    (output stb, we, addr, wdata, input  rdata, ack, err);
  modport slave     (input  stb, we, addr, wdata, output rdata, ack, err);
  modport initiator (output stb, we, addr, wdata, input  rdata, ack);
endinterface

// File: rtl/uart_wb_arbiter.sv
// Two-master round-robin arbiter and transaction sequencer for the UART
// register port. Each request is latched on grant, driven to the UART with a
// stb/ack handshake, and guarded by a watchdog that answers with an error
// (and ERR_DATA) when the UART fails to ack within TIMEOUT edges.
//
// Ports:
//   wb_clk  clock, all logic on the rising edge
//   reset   synchronous, active-high
//   m0      CPU-side master port (slave modport)
//   m1      boot/debug loader master port (slave modport)
//   s       UART register port (initiator modport)
//   grant   one-hot owner of the current transfer, 00 when idle
module uart_wb_arbiter #(
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [7:0]  ERR_DATA = 8'hFF
) (
  input  logic                  wb_clk,
  input  logic                  reset,
  uart_wb_arbiter_if.slave      m0,
  uart_wb_arbiter_if.slave      m1,
  uart_wb_arbiter_if.initiator  s,
  output logic [1:0]            grant
);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, HOLD} state_t;

  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  state_t          state_q, state_d;
  logic            owner_q, owner_d;
  logic            last_q, last_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [1:0]      grant_q, grant_d;
  logic            s_stb_q, s_stb_d;
  logic            s_we_q, s_we_d;
  logic [1:0]      s_addr_q, s_addr_d;
  logic [7:0]      s_wdata_q, s_wdata_d;
  logic [1:0]      ack_q, ack_d;
  logic [1:0]      err_q, err_d;
  logic [1:0][7:0] rdata_q, rdata_d;
  logic            owner_stb;
  logic            winner;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    s_stb_d   = s_stb_q;
    s_we_d    = s_we_q;
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;
    ack_d     = ack_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    owner_stb = owner_q ? m1.stb : m0.stb;
    winner    = 1'b0;

    case (state_q)
      IDLE: begin
        // A lingering s_ack from the previous transfer must not be credited
        // to the next owner, so no grant is issued until it has dropped.
        if (!s.ack && (m0.stb || m1.stb)) begin
          // On a tie the master that did not own the bus last time wins.
          winner    = (m0.stb && m1.stb) ? ~last_q : m1.stb;
          owner_d   = winner;
          grant_d   = winner ? 2'b10 : 2'b01;
          s_we_d    = winner ? m1.we    : m0.we;
          s_addr_d  = winner ? m1.addr  : m0.addr;
          s_wdata_d = winner ? m1.wdata : m0.wdata;
          s_stb_d   = 1'b1;
          cnt_d     = 8'd0;
          state_d   = WAIT_ACK;
        end
      end

      WAIT_ACK: begin
        // An ack arriving on the final watchdog edge still counts as success.
        if (s.ack) begin
          rdata_d[owner_q] = s.rdata;
          ack_d[owner_q]   = 1'b1;
          s_stb_d          = 1'b0;
          state_d          = HOLD;
        end else if (cnt_q == LAST_CNT) begin
          rdata_d[owner_q] = ERR_DATA;
          err_d[owner_q]   = 1'b1;
          s_stb_d          = 1'b0;
          state_d          = HOLD;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      HOLD: begin
        // ack/err follow the owner's stb, so an owner that already let go
        // sees the response for a single cycle. The bus is only released
        // once the UART has also dropped its ack.
        if (!owner_stb) begin
          ack_d = 2'b00;
          err_d = 2'b00;
          if (!s.ack) begin
            grant_d = 2'b00;
            last_d  = owner_q;
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk) begin
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      cnt_q     <= 8'd0;
      grant_q   <= 2'b00;
      s_stb_q   <= 1'b0;
      s_we_q    <= 1'b0;
      s_addr_q  <= 2'b00;
      s_wdata_q <= 8'h00;
      ack_q     <= 2'b00;
      err_q     <= 2'b00;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      s_stb_q   <= s_stb_d;
      s_we_q    <= s_we_d;
      s_addr_q  <= s_addr_d;
      s_wdata_q <= s_wdata_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  assign m0.rdata = rdata_q[0];
  assign m0.ack   = ack_q[0];
  assign m0.err   = err_q[0];
  assign m1.rdata = rdata_q[1];
  assign m1.ack   = ack_q[1];
  assign m1.err   = err_q[1];
  assign s.stb    = s_stb_q;
  assign s.we     = s_we_q;
  assign s.addr   = s_addr_q;
  assign s.wdata  = s_wdata_q;
  assign grant    = grant_q;

endmodule

// File: tb/tb_uart_wb_arbiter.sv
// Self-checking bench for uart_wb_arbiter. Two scripted masters and a UART
// model with a programmable ack delay drive the arbiter; expected owners,
// response kinds, latencies and data come from a transaction-level model
// (round-robin order, "ack if the UART answers within TIMEOUT edges, else
// error at TIMEOUT").
module tb_uart_wb_arbiter;
  localparam int         TIMEOUT  = 16;
  localparam logic [7:0] ERR_DATA = 8'hFF;
  localparam int         NEVER    = 1000;

  logic       wb_clk;
  logic       reset;
  logic [1:0] grant;

  uart_wb_arbiter_if m0_if ();
  uart_wb_arbiter_if m1_if ();
  uart_wb_arbiter_if s_if ();

  uart_wb_arbiter #(.TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA)) dut (
    .wb_clk (wb_clk),
    .reset  (reset),
    .m0     (m0_if),
    .m1     (m1_if),
    .s      (s_if),
    .grant  (grant)
  );

  int         tests_run    = 0;
  int         tests_failed = 0;
  int         edge_count   = 0;
  int         ack_delay    = 0;
  int         wait_cnt     = 0;
  logic [7:0] slave_data   = 8'h00;
  logic [7:0] slave_queue[$];
  logic       last_grant   = 1'b1;
  logic       monitor_on   = 1'b0;
  logic       stb_seen, ack_seen, reset_seen;

  initial begin
    wb_clk = 1'b0;
    forever #5 wb_clk = ~wb_clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  always @(posedge wb_clk) edge_count++;

  // UART model: acks ack_delay edges after first seeing stb, drops ack the
  // edge after stb goes low.
  always @(posedge wb_clk) begin
    stb_seen   = s_if.stb;
    ack_seen   = s_if.ack;
    reset_seen = reset;
    #1;
    if (reset_seen || !stb_seen) begin
      s_if.ack = 1'b0;
      wait_cnt = 0;
    end else if (!ack_seen) begin
      if (wait_cnt >= ack_delay) begin
        slave_data = (slave_queue.size() > 0) ? slave_queue.pop_front() : 8'($urandom);
        s_if.rdata = slave_data;
        s_if.ack   = 1'b1;
      end else begin
        wait_cnt++;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  always @(negedge wb_clk) begin
    if (monitor_on) begin
      checkOutput("flags_onehot0", 32'($onehot0({m0_if.ack, m0_if.err, m1_if.ack, m1_if.err})), 32'd1);
      checkOutput("grant_onehot0", 32'($onehot0(grant)), 32'd1);
    end
  end

  task automatic applyStimulus(input int m, input logic stb, input logic we,
                               input logic [1:0] addr, input logic [7:0] wdata);
    if (m == 0) begin
      m0_if.stb = stb; m0_if.we = we; m0_if.addr = addr; m0_if.wdata = wdata;
    end else begin
      m1_if.stb = stb; m1_if.we = we; m1_if.addr = addr; m1_if.wdata = wdata;
    end
  endtask

  function automatic logic [1:0] flagsOf(input int m);
    return (m == 0) ? {m0_if.ack, m0_if.err} : {m1_if.ack, m1_if.err};
  endfunction

  function automatic logic [7:0] rdataOf(input int m);
    return (m == 0) ? m0_if.rdata : m1_if.rdata;
  endfunction

  function automatic int pickDelay();
    case ($urandom_range(0, 7))
      5:       return TIMEOUT - 2;
      6:       return TIMEOUT - 1;
      7:       return NEVER;
      default: return int'($urandom_range(0, 4));
    endcase
  endfunction

  task automatic dropAll();
    applyStimulus(0, 1'b0, 1'b0, 2'b00, 8'h00);
    applyStimulus(1, 1'b0, 1'b0, 2'b00, 8'h00);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_bus"}, {grant, s_if.stb, s_if.we, s_if.addr, s_if.wdata}, 32'd0);
    checkOutput({tag, "_masters"}, {m0_if.ack, m0_if.err, m0_if.rdata, m1_if.ack, m1_if.err, m1_if.rdata}, 32'd0);
  endtask

  // pattern 0: m0 alone, 1: m1 alone, 2: both together,
  // 3: m0 alone, m1 joins once m0 owns the bus
  task automatic runRound(input int pattern, input logic [1:0] we, input logic [1:0][1:0] addr,
                          input logic [1:0][7:0] wdata, input int d_first, input int d_second);
    int   order[$];
    int   waited, lat, exp_lat, owner, cur_delay, g_edge, hold_cycles;
    logic timed_out, exp_ack;
    case (pattern)
      0:       order = {0};
      1:       order = {1};
      2:       order = {int'(!last_grant), int'(last_grant)};
      default: order = {0, 1};
    endcase
    ack_delay = d_first;
    if (pattern != 1) applyStimulus(0, 1'b1, we[0], addr[0], wdata[0]);
    if (pattern == 1 || pattern == 2) applyStimulus(1, 1'b1, we[1], addr[1], wdata[1]);

    foreach (order[i]) begin
      owner     = order[i];
      cur_delay = (i == 0) ? d_first : d_second;
      ack_delay = cur_delay;

      waited = 0;
      do begin @(negedge wb_clk); waited++; end while (grant == 2'b00 && waited < 40);
      timed_out = (grant == 2'b00);
      checkOutput("grant_wait_expired", 32'(timed_out), 32'd0);
      if (timed_out) begin dropAll(); return; end
      if (i == 0) checkOutput("grant_latency", waited, 1);
      checkOutput("grant_owner", grant, (owner == 0) ? 2'b01 : 2'b10);
      checkOutput("s_stb_at_grant", s_if.stb, 1'b1);
      checkOutput("s_req_at_grant", {s_if.we, s_if.addr, s_if.wdata}, {we[owner], addr[owner], wdata[owner]});
      g_edge = edge_count;
      if (pattern == 3 && i == 0) applyStimulus(1, 1'b1, we[1], addr[1], wdata[1]);
      applyStimulus(owner, 1'b1, ~we[owner], 2'(addr[owner] + 2'd1), ~wdata[owner]);

      waited = 0;
      do begin @(negedge wb_clk); waited++; end while (flagsOf(owner) == 2'b00 && waited < 40);
      timed_out = (flagsOf(owner) == 2'b00);
      checkOutput("resp_wait_expired", 32'(timed_out), 32'd0);
      if (timed_out) begin dropAll(); return; end
      lat     = edge_count - g_edge;
      exp_ack = (cur_delay + 2 <= TIMEOUT);
      exp_lat = exp_ack ? cur_delay + 2 : TIMEOUT;
      checkOutput("resp_latency", lat, exp_lat);
      checkOutput("resp_kind", flagsOf(owner), exp_ack ? 2'b10 : 2'b01);
      checkOutput("resp_rdata", rdataOf(owner), exp_ack ? slave_data : ERR_DATA);
      checkOutput("s_stb_after_resp", s_if.stb, 1'b0);
      checkOutput("other_flags_quiet", flagsOf(1 - owner), 2'b00);
      checkOutput("s_req_held", {s_if.we, s_if.addr, s_if.wdata}, {we[owner], addr[owner], wdata[owner]});

      hold_cycles = int'($urandom_range(0, 3));
      repeat (hold_cycles) begin
        @(negedge wb_clk);
        checkOutput("resp_held", flagsOf(owner), exp_ack ? 2'b10 : 2'b01);
      end
      applyStimulus(owner, 1'b0, 1'b0, 2'b00, 8'h00);

      waited = 0;
      do begin @(negedge wb_clk); waited++; end while (grant != 2'b00 && waited < 10);
      checkOutput("release_wait_expired", 32'(grant != 2'b00), 32'd0);
      checkOutput("flags_cleared", flagsOf(owner), 2'b00);
      last_grant = (owner == 1);
    end
    dropAll();
  endtask

  task automatic resetInHold();
    int waited;
    ack_delay = 0;
    applyStimulus(0, 1'b1, 1'b1, 2'b10, 8'h00);
    waited = 0;
    do begin @(negedge wb_clk); waited++; end while (flagsOf(0) == 2'b00 && waited < 10);
    checkOutput("pre_reset_ack", flagsOf(0), 2'b10);
    reset = 1'b1;
    @(negedge wb_clk);
    checkAllZero("reset_in_hold");
    dropAll();
    reset      = 1'b0;
    last_grant = 1'b1;
  endtask

  initial begin
    reset      = 1'b1;
    s_if.ack   = 1'b0;
    s_if.rdata = 8'h00;
    s_if.err   = 1'b0;
    dropAll();
    repeat (3) @(negedge wb_clk);
    checkAllZero("reset_state");
    reset      = 1'b0;
    monitor_on = 1'b1;

    // m0 write of 'A' to address 0
    runRound(0, 2'b00, {2'b00, 2'b00}, {8'h00, 8'h41}, 0, 0);
    // m1 arrives while m0 owns the bus
    runRound(3, 2'($urandom), 4'($urandom), 16'($urandom), 2, 0);
    // UART never answers
    runRound(0, 2'b11, {2'b00, 2'b01}, 16'h0000, NEVER, 0);
    // ack lands on the last watchdog edge, then one that misses it
    runRound(1, 2'b11, {2'b01, 2'b00}, 16'h0000, TIMEOUT - 2, 0);
    runRound(1, 2'b11, {2'b01, 2'b00}, 16'h0000, TIMEOUT - 1, 0);
    // reset while m0 is being acked, then two tied pairs
    resetInHold();
    slave_queue = {8'h55, 8'hAA};
    runRound(2, 2'b11, {2'b01, 2'b01}, 16'h0000, 0, 0);
    runRound(2, 2'b11, {2'b01, 2'b01}, 16'h0000, 0, 1);

    for (int r = 0; r < 30; r++) begin
      runRound(int'($urandom_range(0, 3)), 2'($urandom), 4'($urandom), 16'($urandom),
               pickDelay(), pickDelay());
    end

    monitor_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
